// File: rtl/game_flow_ctrl.sv
// Rhythm-game sequencer: menu/arm/play/results flow, chart player config,
// saturating hit score and a best score per chart.
module game_flow_ctrl #(
    parameter int NUM_CHARTS          = 2,
    parameter int SCORE_W             = 10,
    parameter int ARM_FRAMES          = 4,
    parameter int RESULT_FRAMES       = 300,
    parameter int PLAY_TIMEOUT_FRAMES = 7200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_done,
    input  logic               start_btn,
    input  logic               speed_btn,
    input  logic               sel_btn,
    input  logic               abort_btn,
    input  logic               hit_pulse,
    input  logic               chart_done,
    output logic               chart_rst_n,
    output logic [1:0]         chart_sel,
    output logic [1:0]         note_speed,
    output logic [1:0]         game_state,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] best_score,
    output logic               new_best
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        PLAY    = 2'd2,
        RESULTS = 2'd3
    } state_t;

    localparam logic [15:0] ARM_LAST  = 16'(ARM_FRAMES - 1);
    localparam logic [15:0] PLAY_LAST = 16'(PLAY_TIMEOUT_FRAMES - 1);
    localparam logic [15:0] RES_LAST  = 16'(RESULT_FRAMES - 1);
    localparam logic [1:0]  SEL_LAST  = 2'(NUM_CHARTS - 1);

    state_t             state, state_d;
    logic [15:0]        cnt, cnt_d;
    logic [SCORE_W-1:0] score_d, score_inc;
    logic [SCORE_W-1:0] best_q [4];
    logic [1:0]         sel_d, speed_d;
    logic               new_best_d, best_wr;

    logic start_q, speed_q, sel_q, abort_q, frame_q;
    logic start_e, speed_e, sel_e, abort_e, tick;

    assign start_e = start_btn & ~start_q;
    assign speed_e = speed_btn & ~speed_q;
    assign sel_e   = sel_btn & ~sel_q;
    assign abort_e = abort_btn & ~abort_q;
    assign tick    = frame_done & ~frame_q;

    assign game_state = state;
    assign best_score = best_q[chart_sel];
    assign score_inc  = (&score) ? score : score + SCORE_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q <= 1'b0;
            speed_q <= 1'b0;
            sel_q   <= 1'b0;
            abort_q <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            start_q <= start_btn;
            speed_q <= speed_btn;
            sel_q   <= sel_btn;
            abort_q <= abort_btn;
            frame_q <= frame_done;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            score       <= '0;
            new_best    <= 1'b0;
            chart_sel   <= 2'd0;
            note_speed  <= 2'd1;
            chart_rst_n <= 1'b0;
            for (int i = 0; i < 4; i++) best_q[i] <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            score       <= score_d;
            new_best    <= new_best_d;
            chart_sel   <= sel_d;
            note_speed  <= speed_d;
            chart_rst_n <= (state == PLAY);
            if (best_wr) best_q[chart_sel] <= score_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        score_d    = score;
        new_best_d = new_best;
        sel_d      = chart_sel;
        speed_d    = note_speed;
        best_wr    = 1'b0;
        case (state)
            IDLE: begin
                if (speed_e) speed_d = (note_speed == 2'd3) ? 2'd1 : note_speed + 2'd1;
                if (sel_e)   sel_d   = (chart_sel == SEL_LAST) ? 2'd0 : chart_sel + 2'd1;
                if (start_e) begin
                    score_d = '0;
                    cnt_d   = '0;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (tick) begin
                    if (cnt == ARM_LAST) begin
                        cnt_d   = '0;
                        state_d = PLAY;
                    end else begin
                        cnt_d = cnt + 16'd1;
                    end
                end
            end
            PLAY: begin
                if (hit_pulse) score_d = score_inc;
                if (tick)      cnt_d   = cnt + 16'd1;
                // chart_rst_n is still low on the first PLAY cycle, so it masks a stale chart_done
                if (abort_e) begin
                    state_d = IDLE;
                end else if ((chart_done && chart_rst_n) || (tick && cnt == PLAY_LAST)) begin
                    state_d = RESULTS;
                    cnt_d   = '0;
                    if (score_d > best_q[chart_sel]) begin
                        best_wr    = 1'b1;
                        new_best_d = 1'b1;
                    end else begin
                        new_best_d = 1'b0;
                    end
                end
            end
            RESULTS: begin
                if (tick) cnt_d = cnt + 16'd1;
                if (start_e || (tick && cnt == RES_LAST)) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    new_best_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl; expectations go through a scoreboard queue
// and are checked with immediate assertions.
module tb_game_flow_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic frame_done = 1'b0, start_btn = 1'b0, speed_btn = 1'b0, sel_btn = 1'b0;
    logic abort_btn = 1'b0, hit_pulse = 1'b0, chart_done = 1'b0;

    logic       chart_rst_n, new_best;
    logic [1:0] chart_sel, note_speed, game_state;
    logic [9:0] score, best_score;

    logic       s_chart_rst_n, s_new_best;
    logic [1:0] s_chart_sel, s_note_speed, s_game_state;
    logic [2:0] s_score, s_best_score;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    game_flow_ctrl dut (
        .clk(clk), .rst(rst), .frame_done(frame_done), .start_btn(start_btn),
        .speed_btn(speed_btn), .sel_btn(sel_btn), .abort_btn(abort_btn),
        .hit_pulse(hit_pulse), .chart_done(chart_done), .chart_rst_n(chart_rst_n),
        .chart_sel(chart_sel), .note_speed(note_speed), .game_state(game_state),
        .score(score), .best_score(best_score), .new_best(new_best)
    );

    game_flow_ctrl #(.SCORE_W(3)) dut_sat (
        .clk(clk), .rst(rst), .frame_done(frame_done), .start_btn(start_btn),
        .speed_btn(speed_btn), .sel_btn(sel_btn), .abort_btn(abort_btn),
        .hit_pulse(hit_pulse), .chart_done(chart_done), .chart_rst_n(s_chart_rst_n),
        .chart_sel(s_chart_sel), .note_speed(s_note_speed), .game_state(s_game_state),
        .score(s_score), .best_score(s_best_score), .new_best(s_new_best)
    );

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed %0d", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (e.tag == tag && obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d (queued as %s)", tag, obs, e.val, e.tag);
            end
        end
    endtask

    // advance n rising edges, landing 1ns after the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            frame_done = 1'b1; step(1);
            frame_done = 1'b0; step(1);
        end
    endtask

    task automatic hit(input int n);
        repeat (n) begin
            hit_pulse = 1'b1; step(1);
            hit_pulse = 1'b0; step(1);
        end
    endtask

    task automatic press_start();
        start_btn = 1'b1; step(1);
        start_btn = 1'b0; step(1);
    endtask

    task automatic arm_to_play();
        press_start();
        tick(4);
        step(1);
    endtask

    task automatic chk_reset_vals(input string pfx);
        push({pfx, "_state"}, 0);  pop_chk({pfx, "_state"}, 32'(game_state));
        push({pfx, "_crst"}, 0);   pop_chk({pfx, "_crst"}, 32'(chart_rst_n));
        push({pfx, "_sel"}, 0);    pop_chk({pfx, "_sel"}, 32'(chart_sel));
        push({pfx, "_speed"}, 1);  pop_chk({pfx, "_speed"}, 32'(note_speed));
        push({pfx, "_score"}, 0);  pop_chk({pfx, "_score"}, 32'(score));
        push({pfx, "_best"}, 0);   pop_chk({pfx, "_best"}, 32'(best_score));
        push({pfx, "_nbest"}, 0);  pop_chk({pfx, "_nbest"}, 32'(new_best));
        push({pfx, "_s_state"}, 0); pop_chk({pfx, "_s_state"}, 32'(s_game_state));
        push({pfx, "_s_score"}, 0); pop_chk({pfx, "_s_score"}, 32'(s_score));
        push({pfx, "_s_crst"}, 0);  pop_chk({pfx, "_s_crst"}, 32'(s_chart_rst_n));
    endtask

    initial begin
        step(2);
        chk_reset_vals("rst");
        rst = 1'b1;
        step(1);

        // IDLE configuration
        speed_btn = 1'b1; step(1); speed_btn = 1'b0; step(1);
        push("speed_2", 2); pop_chk("speed_2", 32'(note_speed));
        speed_btn = 1'b1; step(1); speed_btn = 1'b0; step(1);
        speed_btn = 1'b1; step(1); speed_btn = 1'b0; step(1);
        push("speed_wrap", 1); pop_chk("speed_wrap", 32'(note_speed));
        sel_btn = 1'b1; step(1); sel_btn = 1'b0; step(1);
        push("sel_1", 1); pop_chk("sel_1", 32'(chart_sel));
        push("idle_crst", 0); pop_chk("idle_crst", 32'(chart_rst_n));

        // ARM lasts exactly four frame ticks and ignores buttons
        start_btn = 1'b1; step(1); start_btn = 1'b0;
        push("arm_enter", 1); pop_chk("arm_enter", 32'(game_state));
        step(1);
        speed_btn = 1'b1; sel_btn = 1'b1; step(1); speed_btn = 1'b0; sel_btn = 1'b0; step(1);
        push("arm_speed_hold", 1); pop_chk("arm_speed_hold", 32'(note_speed));
        push("arm_sel_hold", 1);   pop_chk("arm_sel_hold", 32'(chart_sel));
        tick(3);
        push("arm_3ticks", 1); pop_chk("arm_3ticks", 32'(game_state));
        frame_done = 1'b1; step(1);
        push("play_enter", 2); pop_chk("play_enter", 32'(game_state));
        push("play_crst_lag", 0); pop_chk("play_crst_lag", 32'(chart_rst_n));
        frame_done = 1'b0; step(1);
        push("play_crst", 1); pop_chk("play_crst", 32'(chart_rst_n));

        // five hits, the last one together with chart_done
        hit(4);
        hit_pulse = 1'b1; chart_done = 1'b1; step(1);
        hit_pulse = 1'b0; chart_done = 1'b0;
        push("res_state", 3); pop_chk("res_state", 32'(game_state));
        push("res_score", 5); pop_chk("res_score", 32'(score));
        push("res_best", 5);  pop_chk("res_best", 32'(best_score));
        push("res_nbest", 1); pop_chk("res_nbest", 32'(new_best));
        hit(1);
        push("res_hit_ign", 5); pop_chk("res_hit_ign", 32'(score));
        press_start();
        push("res_to_idle", 0); pop_chk("res_to_idle", 32'(game_state));
        push("idle_nbest", 0);  pop_chk("idle_nbest", 32'(new_best));
        push("idle_score", 5);  pop_chk("idle_score", 32'(score));

        // same chart, lower score
        arm_to_play();
        push("rerun_score0", 0); pop_chk("rerun_score0", 32'(score));
        hit(3);
        chart_done = 1'b1; step(1); chart_done = 1'b0;
        push("rerun_state", 3); pop_chk("rerun_state", 32'(game_state));
        push("rerun_score", 3); pop_chk("rerun_score", 32'(score));
        push("rerun_best", 5);  pop_chk("rerun_best", 32'(best_score));
        push("rerun_nbest", 0); pop_chk("rerun_nbest", 32'(new_best));
        press_start();

        // abort mid-play
        arm_to_play();
        hit(2);
        abort_btn = 1'b1; step(1); abort_btn = 1'b0;
        push("abort_state", 0); pop_chk("abort_state", 32'(game_state));
        push("abort_score", 2); pop_chk("abort_score", 32'(score));
        push("abort_best", 5);  pop_chk("abort_best", 32'(best_score));
        step(1);
        push("abort_crst", 0); pop_chk("abort_crst", 32'(chart_rst_n));

        // watchdog timeout, then auto-return from RESULTS
        arm_to_play();
        tick(7199);
        push("wd_7199", 2); pop_chk("wd_7199", 32'(game_state));
        tick(1);
        push("wd_7200", 3); pop_chk("wd_7200", 32'(game_state));
        push("wd_nbest", 0); pop_chk("wd_nbest", 32'(new_best));
        tick(299);
        push("res_299", 3); pop_chk("res_299", 32'(game_state));
        tick(1);
        push("res_300", 0); pop_chk("res_300", 32'(game_state));

        // saturation on the narrow instance, then reset mid-play
        arm_to_play();
        hit(10);
        push("sat_score", 7);   pop_chk("sat_score", 32'(s_score));
        push("wide_score", 10); pop_chk("wide_score", 32'(score));
        push("sat_state", 2);   pop_chk("sat_state", 32'(s_game_state));
        rst = 1'b0;
        #1;
        chk_reset_vals("midrst");
        push("midrst_s_best", 0); pop_chk("midrst_s_best", 32'(s_best_score));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
